// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU and its writeback stage:
//   - opcode constants (5-bit encoding used on the ALU output interface)
//   - status register bit indices
//   - writeback sequencer state enum
//   - opcode classifier functions used by the writeback stage
package alu_pkg;

  localparam logic [4:0] OPC_NOP   = 5'h00;
  localparam logic [4:0] OPC_LOAD  = 5'h01;
  localparam logic [4:0] OPC_STORE = 5'h02;
  localparam logic [4:0] OPC_AND   = 5'h03;
  localparam logic [4:0] OPC_OR    = 5'h04;
  localparam logic [4:0] OPC_XOR   = 5'h05;
  localparam logic [4:0] OPC_ADD   = 5'h06;
  localparam logic [4:0] OPC_ADDC  = 5'h07;
  localparam logic [4:0] OPC_SUB   = 5'h08;
  localparam logic [4:0] OPC_MUL   = 5'h09;
  localparam logic [4:0] OPC_DIV   = 5'h0A;
  localparam logic [4:0] OPC_SDIV  = 5'h0B;

  localparam int ST_ZERO    = 0;
  localparam int ST_CARRY   = 1;
  localparam int ST_NEG     = 2;
  localparam int ST_WIDE_NZ = 3;

  // EMPTY: no beat pending; LO: low/normal word on the write port;
  // HI: high word (MUL) or remainder (DIV) on the write port
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LO    = 2'd1,
    HI    = 2'd2
  } wb_state_e;

  // Opcodes that produce a register-file write (AND through DIV).
  // LOAD is written back by the memory path, SDIV is not handled here.
  function automatic logic opc_writes(input logic [4:0] opc);
    return (opc >= OPC_AND) && (opc <= OPC_DIV);
  endfunction

  // Opcodes whose second result word also goes to the register file
  function automatic logic opc_wide(input logic [4:0] opc);
    return (opc == OPC_MUL) || (opc == OPC_DIV);
  endfunction

endpackage

// File: rtl/alu_writeback.sv
// alu_writeback
// Receiving end of the ALU output interface. Accepts one ALU result per
// valid/ready handshake and sequences the register-file write port: one
// beat for normal results, two beats (rd, then rd+1) for MUL/DIV. Also owns
// the architectural status register that feeds the ALU statusIn.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_valid      ALU result valid
//   in_ready      block can accept a result this cycle
//   in_opc        opcode of the result
//   in_rd         destination register
//   in_result     ALU OutA
//   in_overflow   MUL high word / DIV remainder
//   in_status     ALU statusOut
//   rf_stall      register file cannot take a write this cycle
//   wr_en/addr/data  register-file write port
//   status_reg    architectural status
//   wb_count      number of completed write beats (wraps)
module alu_writeback
  import alu_pkg::*;
#(
  parameter int RA_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_opc,
  input  logic [RA_W-1:0]  in_rd,
  input  logic [31:0]      in_result,
  input  logic [31:0]      in_overflow,
  input  logic [7:0]       in_status,
  input  logic             rf_stall,
  output logic             wr_en,
  output logic [RA_W-1:0]  wr_addr,
  output logic [31:0]      wr_data,
  output logic [7:0]       status_reg,
  output logic [CNT_W-1:0] wb_count
);

  wb_state_e        state_q, state_d;
  logic [4:0]       opc_q;
  logic [RA_W-1:0]  rd_q;
  logic [31:0]      result_q;
  logic [31:0]      overflow_q;
  logic [7:0]       status_q, status_d;
  logic [CNT_W-1:0] count_q;

  logic accept;
  logic held_wide;
  logic beat_done;
  logic unused_status;

  // Upper status bits from the ALU are not architectural here
  assign unused_status = ^in_status[7:3];

  assign held_wide = opc_wide(opc_q);
  assign beat_done = (state_q != EMPTY) && !rf_stall;
  assign accept    = in_valid && in_ready;

  // Ready depends only on registered state and rf_stall, never on in_valid:
  // a new result may enter whenever the current last beat is leaving.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      EMPTY:   in_ready = 1'b1;
      LO:      in_ready = !rf_stall && !held_wide;
      HI:      in_ready = !rf_stall;
      default: in_ready = 1'b0;
    endcase
  end

  // Next-state logic for the write-beat sequencer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (accept && opc_writes(in_opc)) state_d = LO;
      end
      LO: begin
        if (!rf_stall) begin
          if (held_wide)                         state_d = HI;
          else if (accept && opc_writes(in_opc)) state_d = LO;
          else                                   state_d = EMPTY;
        end
      end
      HI: begin
        if (!rf_stall) begin
          if (accept && opc_writes(in_opc)) state_d = LO;
          else                              state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // New status value; the wide-nonzero flag records a nonzero second word
  always_comb begin
    status_d = status_q;
    if (accept && (in_opc != OPC_NOP)) begin
      status_d             = '0;
      status_d[ST_ZERO]    = in_status[ST_ZERO];
      status_d[ST_CARRY]   = in_status[ST_CARRY];
      status_d[ST_NEG]     = in_status[ST_NEG];
      status_d[ST_WIDE_NZ] = opc_wide(in_opc) && (in_overflow != '0);
    end
  end

  // State, holding registers, status and beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      opc_q      <= '0;
      rd_q       <= '0;
      result_q   <= '0;
      overflow_q <= '0;
      status_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      if (accept) begin
        opc_q      <= in_opc;
        rd_q       <= in_rd;
        result_q   <= in_result;
        overflow_q <= in_overflow;
      end
      if (beat_done) count_q <= count_q + CNT_W'(1);
    end
  end

  // Write port is a pure decode of registered state and holding registers
  assign wr_en      = (state_q != EMPTY);
  assign wr_addr    = (state_q == HI) ? rd_q + RA_W'(1) : rd_q;
  assign wr_data    = (state_q == HI) ? overflow_q : result_q;
  assign status_reg = status_q;
  assign wb_count   = count_q;

endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback
// Self-checking bench for alu_writeback. A reference model keeps a queue of
// pending register-file write beats; the head of the queue is what the
// write port must present, and a new result may be accepted once at most
// one beat is left and that beat is leaving this cycle.
module tb_alu_writeback;

  localparam int RA_W  = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_opc;
  logic [RA_W-1:0]  in_rd;
  logic [31:0]      in_result;
  logic [31:0]      in_overflow;
  logic [7:0]       in_status;
  logic             rf_stall;
  logic             wr_en;
  logic [RA_W-1:0]  wr_addr;
  logic [31:0]      wr_data;
  logic [7:0]       status_reg;
  logic [CNT_W-1:0] wb_count;

  typedef struct {
    logic [RA_W-1:0] addr;
    logic [31:0]     data;
  } beat_t;

  beat_t            beatQ[$];
  logic [7:0]       modelStatus;
  logic [CNT_W-1:0] modelCount;

  int testCount = 0;
  int failCount = 0;

  alu_writeback #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opc      (in_opc),
    .in_rd       (in_rd),
    .in_result   (in_result),
    .in_overflow (in_overflow),
    .in_status   (in_status),
    .rf_stall    (rf_stall),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .status_reg  (status_reg),
    .wb_count    (wb_count)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it and reports a failure with observed/expected
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, compare the DUT against
  // the model, then advance the model across the rising edge.
  task automatic applyStimulus(input logic v, input logic [4:0] opc, input logic [RA_W-1:0] rd,
                               input logic [31:0] res, input logic [31:0] ovf,
                               input logic [7:0] st, input logic stall);
    logic            expReady;
    logic            isWrite;
    logic            isWide;
    logic [RA_W-1:0] nextRd;
    @(negedge clk);
    in_valid    = v;
    in_opc      = opc;
    in_rd       = rd;
    in_result   = res;
    in_overflow = ovf;
    in_status   = st;
    rf_stall    = stall;
    #1;
    expReady = (beatQ.size() == 0) || (beatQ.size() == 1 && !stall);
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, expReady});
    checkOutput("wr_en", {31'd0, wr_en}, {31'd0, beatQ.size() != 0});
    if (beatQ.size() != 0) begin
      checkOutput("wr_addr", {28'd0, wr_addr}, {28'd0, beatQ[0].addr});
      checkOutput("wr_data", wr_data, beatQ[0].data);
    end
    checkOutput("status_reg", {24'd0, status_reg}, {24'd0, modelStatus});
    checkOutput("wb_count", {16'd0, wb_count}, {16'd0, modelCount});
    @(posedge clk);
    if (beatQ.size() != 0 && !stall) begin
      void'(beatQ.pop_front());
      modelCount = modelCount + 1'b1;
    end
    if (v && expReady) begin
      isWrite = (opc >= 5'd3) && (opc <= 5'd10);
      isWide  = (opc == 5'd9) || (opc == 5'd10);
      if (opc != 5'd0)
        modelStatus = {4'b0000, isWide && (ovf != 32'd0), st[2:0]};
      if (isWrite) beatQ.push_back('{addr: rd, data: res});
      if (isWide) begin
        nextRd = rd + 1'b1;
        beatQ.push_back('{addr: nextRd, data: ovf});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, '0, 32'd0, 32'd0, 8'd0, 1'b0);
  endtask

  // Directed sequence followed by randomized traffic
  initial begin
    logic            rv;
    logic [4:0]      ropc;
    logic [RA_W-1:0] rrd;
    logic [31:0]     rres;
    logic [31:0]     rovf;
    logic [7:0]      rst8;
    logic            rstall;

    rst = 1'b1;
    in_valid = 1'b0; in_opc = '0; in_rd = '0; in_result = '0;
    in_overflow = '0; in_status = '0; rf_stall = 1'b0;
    beatQ.delete();
    modelStatus = '0;
    modelCount  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    checkOutput("rst_wr_data", wr_data, 32'd0);
    checkOutput("rst_status", {24'd0, status_reg}, 32'd0);
    checkOutput("rst_count", {16'd0, wb_count}, 32'd0);
    checkOutput("rst_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    // ADD rd=3, result=5
    applyStimulus(1'b1, 5'h06, 4'd3, 32'h5, 32'h0, 8'h00, 1'b0);
    idle(2);

    // MUL rd=15: beats at 15 then wrapped address 0
    applyStimulus(1'b1, 5'h09, 4'd15, 32'h89ABCDEF, 32'h01234567, 8'h00, 1'b0);
    idle(3);

    // ADD producing carry, then ADDC back to back, then one more
    applyStimulus(1'b1, 5'h06, 4'd1, 32'h11, 32'h0, 8'h02, 1'b0);
    applyStimulus(1'b1, 5'h07, 4'd2, 32'h22, 32'h0, 8'h00, 1'b0);
    checkOutput("carry_seen_by_addc", {31'd0, status_reg[1]}, 32'd1);
    applyStimulus(1'b1, 5'h04, 4'd4, 32'h44, 32'h0, 8'h04, 1'b0);
    idle(2);

    // Beat stalled for 3 cycles while a new result waits unaccepted
    applyStimulus(1'b1, 5'h08, 4'd7, 32'hDEAD0007, 32'h0, 8'h01, 1'b0);
    repeat (3) applyStimulus(1'b1, 5'h03, 4'd8, 32'hBEEF0008, 32'h0, 8'h00, 1'b1);
    applyStimulus(1'b0, 5'h00, 4'd0, 32'h0, 32'h0, 8'h00, 1'b0);
    idle(1);

    // STORE updates status without a write; NOP leaves status alone
    applyStimulus(1'b1, 5'h02, 4'd5, 32'h55, 32'h0, 8'h05, 1'b0);
    applyStimulus(1'b1, 5'h00, 4'd6, 32'h66, 32'h0, 8'h02, 1'b0);
    idle(2);

    // DIV with reset landing during the remainder beat
    applyStimulus(1'b1, 5'h0A, 4'd9, 32'h0000000A, 32'h00000003, 8'h00, 1'b0);
    applyStimulus(1'b0, 5'h00, 4'd0, 32'h0, 32'h0, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("midrst_wr_addr", {28'd0, wr_addr}, 32'd0);
    checkOutput("midrst_wr_data", wr_data, 32'd0);
    checkOutput("midrst_status", {24'd0, status_reg}, 32'd0);
    checkOutput("midrst_count", {16'd0, wb_count}, 32'd0);
    beatQ.delete();
    modelStatus = '0;
    modelCount  = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rv     = ($urandom_range(0, 3) != 0);
      ropc   = 5'($urandom_range(0, 31));
      rrd    = RA_W'($urandom_range(0, 15));
      rres   = $urandom;
      rovf   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rst8   = 8'($urandom_range(0, 255));
      rstall = ($urandom_range(0, 3) == 0);
      applyStimulus(rv, ropc, rrd, rres, rovf, rst8, rstall);
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
